scan_ctrl: RTL and testbench

Raster-scan sequencer for the image-processing datapath. On a start pulse it walks an IMG_W x IMG_H frame pixel by pixel and emits x/y coordinates, a linear pixel address and line/frame markers to downstream pixel stages. It honours ready backpressure, inserts a programmable horizontal blank between lines, and reports completion with a busy/done handshake.

---
 rtl/scan_pkg.sv | 15 +
 rtl/scan_ctrl_if.sv | 24 ++
 rtl/scan_ctrl_wrap_counter.sv | 26 ++
 rtl/scan_ctrl.sv | 129 ++++++++++++
 tb/tb_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the raster-scan sequencer: FSM encoding and default frame geometry.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_IMG_W  = 100;
  localparam int DEF_IMG_H  = 100;
  localparam int DEF_HBLANK = 2;

endpackage

// File: rtl/scan_ctrl_if.sv
// Pixel coordinate bus from the scan sequencer to downstream pixel stages (valid/ready).
interface scan_ctrl_if #(
  parameter int X_W    = 8,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 14
);
  logic              pix_valid;
  logic              pix_ready;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;
  logic              line_end;
  logic              frame_end;

  modport master (
    output pix_valid, x, y, addr, line_end, frame_end,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, x, y, addr, line_end, frame_end,
    output pix_ready
  );
endinterface

// File: rtl/scan_ctrl_wrap_counter.sv
// Counter 0..MAX that returns to 0 on the enabled cycle it sits at MAX; clr has priority over en.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Raster-scan sequencer: walks an IMG_W x IMG_H frame under ready backpressure,
// inserting HBLANK idle cycles between lines and pulsing done after the last pixel.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int HBLANK = DEF_HBLANK,
  parameter int X_W    = 8,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  scan_ctrl_if.master pix,
  output logic        busy,
  output logic        done
);

  localparam int BLK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  if (IMG_W < 1 || IMG_H < 1) begin : g_chk_geom
    $error("scan_ctrl: IMG_W and IMG_H must be at least 1");
  end
  if (IMG_W - 1 >= 2**X_W) begin : g_chk_x
    $error("scan_ctrl: X_W too narrow for IMG_W");
  end
  if (IMG_H - 1 >= 2**Y_W) begin : g_chk_y
    $error("scan_ctrl: Y_W too narrow for IMG_H");
  end
  if (IMG_W * IMG_H - 1 >= 2**ADDR_W) begin : g_chk_addr
    $error("scan_ctrl: ADDR_W too narrow for IMG_W*IMG_H");
  end

  state_t            state, nxt;
  logic              run, xfer, adv, last_row, line_end;
  logic              x_wrap, blank_wrap, valid_q;
  logic [X_W-1:0]    x_cnt;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] addr_q;

  assign run      = (state == ST_ACTIVE) || (state == ST_HBLANK);
  assign xfer     = (state == ST_ACTIVE) && pix.pix_ready;
  assign adv      = xfer && !abort;
  assign last_row = (y_q == Y_W'(IMG_H - 1));
  assign line_end = (state == ST_ACTIVE) && x_wrap;

  wrap_counter #(.MAX(IMG_W - 1), .W(X_W)) u_x_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (adv),
    .clr   (!run || abort),
    .cnt   (x_cnt),
    .wrap  (x_wrap)
  );

  if (HBLANK > 0) begin : g_blank
    logic [BLK_W-1:0] blank_cnt;
    wrap_counter #(.MAX(HBLANK - 1), .W(BLK_W)) u_blank_cnt (
      .clk   (clk),
      .rst_n (reset),
      .en    (state == ST_HBLANK),
      .clr   ((state != ST_HBLANK) || abort),
      .cnt   (blank_cnt),
      .wrap  (blank_wrap)
    );
  end else begin : g_no_blank
    assign blank_wrap = 1'b1;
  end

  // abort wins over a same-cycle transfer and never produces a done pulse
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start && !abort) nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (abort) begin
          nxt = ST_IDLE;
        end else if (xfer && x_wrap) begin
          if (last_row)        nxt = ST_DONE;
          else if (HBLANK > 0) nxt = ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        if (abort)           nxt = ST_IDLE;
        else if (blank_wrap) nxt = ST_ACTIVE;
      end
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      valid_q <= (nxt == ST_ACTIVE);
      busy    <= (nxt == ST_ACTIVE) || (nxt == ST_HBLANK);
      done    <= (nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q    <= '0;
      addr_q <= '0;
    end else if (!run || abort) begin
      y_q    <= '0;
      addr_q <= '0;
    end else if (adv) begin
      if (x_wrap) y_q <= last_row ? '0 : y_q + Y_W'(1);
      addr_q <= (x_wrap && last_row) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  assign pix.pix_valid = valid_q;
  assign pix.x         = x_cnt;
  assign pix.y         = y_q;
  assign pix.addr      = addr_q;
  assign pix.line_end  = line_end;
  assign pix.frame_end = line_end && last_row;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: 4x3 frames with HBLANK=2 (dut_a) and HBLANK=0 (dut_b) against a pixel-index model.
module tb_scan_ctrl;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b1;
  logic busy_a, done_a, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_ctrl_if #(.X_W(2), .Y_W(2), .ADDR_W(4)) bus_a ();
  scan_ctrl_if #(.X_W(2), .Y_W(2), .ADDR_W(4)) bus_b ();
  assign bus_a.pix_ready = ready;
  assign bus_b.pix_ready = ready;

  scan_ctrl #(.IMG_W(W), .IMG_H(H), .HBLANK(2), .X_W(2), .Y_W(2), .ADDR_W(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pix(bus_a.master), .busy(busy_a), .done(done_a)
  );

  scan_ctrl #(.IMG_W(W), .IMG_H(H), .HBLANK(0), .X_W(2), .Y_W(2), .ADDR_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pix(bus_b.master), .busy(busy_b), .done(done_b)
  );

  // Model: mode 0 idle, 1 emitting pixel p, 2 blanking, 3 done; p is the linear pixel index.
  typedef struct {
    int mode;
    int p;
    int brem;
  } mdl_t;

  mdl_t ma = '{0, 0, 0};
  mdl_t mb = '{0, 0, 0};

  function automatic mdl_t mstep(input mdl_t m, input int w, input int h, input int hb,
                                 input logic st, input logic ab, input logic rd);
    mdl_t r = m;
    case (m.mode)
      0: if (st && !ab) begin r.mode = 1; r.p = 0; end
      1: begin
        if (ab) begin
          r.mode = 0; r.p = 0;
        end else if (rd) begin
          if (m.p == w * h - 1) begin
            r.mode = 3; r.p = 0;
          end else begin
            r.p = m.p + 1;
            if ((m.p % w) == w - 1 && hb > 0) begin r.mode = 2; r.brem = hb; end
          end
        end
      end
      2: begin
        if (ab) begin
          r.mode = 0; r.p = 0;
        end else begin
          r.brem = m.brem - 1;
          if (r.brem == 0) r.mode = 1;
        end
      end
      default: r.mode = 0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma = '{0, 0, 0};
      mb = '{0, 0, 0};
    end else begin
      ma = mstep(ma, W, H, 2, start, abort, ready);
      mb = mstep(mb, W, H, 0, start, abort, ready);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string t, input mdl_t m, input logic v, input int x, input int y,
                     input int a, input logic le, input logic fe, input logic bz, input logic dn);
    bit act;
    act = (m.mode == 1);
    check({t, "_valid"}, int'(v), int'(act));
    check({t, "_x"}, x, m.p % W);
    check({t, "_y"}, y, m.p / W);
    check({t, "_addr"}, a, m.p);
    check({t, "_line_end"}, int'(le), int'(act && (m.p % W) == W - 1));
    check({t, "_frame_end"}, int'(fe), int'(act && m.p == W * H - 1));
    check({t, "_busy"}, int'(bz), int'(m.mode == 1 || m.mode == 2));
    check({t, "_done"}, int'(dn), int'(m.mode == 3));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cmp("a", ma, bus_a.pix_valid, int'(bus_a.x), int'(bus_a.y), int'(bus_a.addr),
          bus_a.line_end, bus_a.frame_end, busy_a, done_a);
      cmp("b", mb, bus_b.pix_valid, int'(bus_b.x), int'(bus_b.y), int'(bus_b.addr),
          bus_b.line_end, bus_b.frame_end, busy_b, done_b);
    end
  end

  typedef struct {
    int done_cyc, done_b_cyc, vcnt, xfers, lecnt, fecnt, fe_addr, stall_cnt, addr19, v19;
    logic [63:0] vmask, bmask, vbmask;
  } res_t;

  // Cycle 0 is the cycle start is driven; must be called just after a falling edge.
  task automatic frame_run(input int s1, input int s2, input int s3, input int stall_addr,
                           input int n, output res_t r);
    int hold = 0;
    r = '{default: 0};
    r.done_cyc = -1; r.done_b_cyc = -1; r.fe_addr = -1; r.addr19 = -1;
    start = 1'b1;
    ready = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start = (k == s1) || (k == s2) || (k == s3);
      if (bus_a.pix_valid && int'(bus_a.addr) == stall_addr && hold < 3) begin
        ready = 1'b0;
        hold++;
      end else begin
        ready = 1'b1;
      end
      if (bus_a.pix_valid) begin
        r.vcnt++;
        r.vmask[k] = 1'b1;
        if (ready) r.xfers++;
        if (int'(bus_a.addr) == stall_addr) r.stall_cnt++;
      end
      if (bus_a.line_end) r.lecnt++;
      if (bus_a.frame_end) begin r.fecnt++; r.fe_addr = int'(bus_a.addr); end
      if (busy_a) r.bmask[k] = 1'b1;
      if (done_a && r.done_cyc < 0) r.done_cyc = k;
      if (done_b && r.done_b_cyc < 0) r.done_b_cyc = k;
      if (bus_b.pix_valid) r.vbmask[k] = 1'b1;
      if (k == 19) begin r.v19 = int'(bus_a.pix_valid); r.addr19 = int'(bus_a.addr); end
    end
    start = 1'b0;
  endtask

  initial begin
    res_t r;
    bit found;
    int dn_seen;

    repeat (3) @(negedge clk);
    check("rst_valid", int'(bus_a.pix_valid), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_addr", int'(bus_a.addr), 0);
    check("rst_done", int'(done_a), 0);
    reset = 1'b1;
    @(negedge clk);

    // Plain frame: lines at 1-4, 7-10, 13-16; HBLANK=0 copy runs 1-12
    frame_run(-1, -1, -1, -1, 24, r);
    check("t1_done_cyc", r.done_cyc, 17);
    check("t1_vmask", int'(r.vmask[31:0]), 32'h0001E79E);
    check("t1_bmask", int'(r.bmask[31:0]), 32'h0001FFFE);
    check("t1_vcnt", r.vcnt, 12);
    check("t1_line_ends", r.lecnt, 3);
    check("t1_frame_ends", r.fecnt, 1);
    check("t1_fe_addr", r.fe_addr, 11);
    check("t6_done_cyc", r.done_b_cyc, 13);
    check("t6_vmask", int'(r.vbmask[31:0]), 32'h00001FFE);

    // Three-cycle stall on addr 5
    frame_run(-1, -1, -1, 5, 26, r);
    check("t2_done_cyc", r.done_cyc, 20);
    check("t2_xfers", r.xfers, 12);
    check("t2_addr5_cycles", r.stall_cnt, 4);
    check("t2_vcnt", r.vcnt, 15);
    check("t2_fe_addr", r.fe_addr, 11);

    // Starts at 3 and 17 are ignored; start at 18 launches a new frame
    frame_run(3, 17, 18, -1, 19, r);
    check("t3_done_cyc", r.done_cyc, 17);
    check("t3_vmask", int'(r.vmask[31:0] & 32'h0003FFFF), 32'h0001E79E);
    check("t3_restart_valid", r.v19, 1);
    check("t3_restart_addr", r.addr19, 0);

    // Abort while addr 6 is offered with ready high
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      ready = 1'b1;
      if (bus_a.pix_valid && bus_a.addr == 4'd6) begin
        abort = 1'b1;
        found = 1'b1;
      end
    end
    check("t4_found_addr6", int'(found), 1);
    @(negedge clk);
    abort = 1'b0;
    check("t4_valid", int'(bus_a.pix_valid), 0);
    check("t4_busy", int'(busy_a), 0);
    check("t4_addr", int'(bus_a.addr), 0);
    check("t4_xy", int'({bus_a.x, bus_a.y}), 0);
    dn_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) dn_seen++;
    end
    check("t4_no_done", dn_seen, 0);

    // Asynchronous reset mid-line
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (bus_a.pix_valid && bus_a.addr == 4'd9) found = 1'b1;
      else @(negedge clk);
    end
    check("t5_found_addr9", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    check("t5_valid", int'(bus_a.pix_valid), 0);
    check("t5_addr", int'(bus_a.addr), 0);
    check("t5_xy", int'({bus_a.x, bus_a.y}), 0);
    check("t5_marks", int'({bus_a.line_end, bus_a.frame_end}), 0);
    check("t5_busy_done", int'({busy_a, done_a}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_restart_valid", int'(bus_a.pix_valid), 1);
    check("t5_restart_addr", int'(bus_a.addr), 0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (done_a) found = 1'b1;
    end
    check("t5_frame_done", int'(found), 1);

    // Randomized traffic checked cycle by cycle against the model
    repeat (3000) begin
      @(negedge clk);
      ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 49) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
